// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared types and constants for the RAM arbiter slice:
//   - state_e : one-hot arbiter states (IDLE, GRANT, RETURN)
//   - owner_e : 2-bit IDs of the three caches (BC, DC, VC)
//   - WRITE_MASK_ALL : full-word byte mask driven to the RAM
//   - fertig_onehot() : maps an owner ID to its {VC, DC, BC} Fertig bit
package ram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_GRANT  = 3'b010,
        ST_RETURN = 3'b100
    } state_e;

    typedef enum logic [1:0] {
        OWNER_BC = 2'd0,
        OWNER_DC = 2'd1,
        OWNER_VC = 2'd2
    } owner_e;

    localparam logic [3:0] WRITE_MASK_ALL = 4'b1111;

    // Bit order {VC, DC, BC}
    function automatic logic [2:0] fertig_onehot(input owner_e owner);
        logic [2:0] f;
        f = '0;
        case (owner)
            OWNER_BC: f = 3'b001;
            OWNER_DC: f = 3'b010;
            OWNER_VC: f = 3'b100;
            default:  f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Bus bundle between the three caches, the arbiter and the external RAM.
//   Cache side : xxSchreiben/xxLesen (level requests), xxAdresse (23 bit word
//                address), xxDaten (write data), xxFertig (completion pulse),
//                DatenAusgabe (returned data).
//   RAM side   : Schreiben/Lesen strobes, Adresse (26 bit), SchreibDaten,
//                WriteMask, LeseDaten, RAMFertig, Zeitueberschreitung.
//   Modports   : slave  - the arbiter
//                master - caches + RAM model driving the arbiter
interface ram_arbiter_if;

    logic        BCSchreiben, BCLesen;
    logic [22:0] BCAdresse;
    logic [31:0] BCDaten;
    logic        BCFertig;

    logic        DCSchreiben, DCLesen;
    logic [22:0] DCAdresse;
    logic [31:0] DCDaten;
    logic        DCFertig;

    logic        VCSchreiben, VCLesen;
    logic [22:0] VCAdresse;
    logic [31:0] VCDaten;
    logic        VCFertig;

    logic [31:0] LeseDaten;
    logic        RAMFertig;
    logic [31:0] DatenAusgabe;
    logic        Schreiben, Lesen;
    logic [25:0] Adresse;
    logic [31:0] SchreibDaten;
    logic [3:0]  WriteMask;
    logic        Zeitueberschreitung;

    modport slave (
        input  BCSchreiben, BCLesen, BCAdresse, BCDaten,
        input  DCSchreiben, DCLesen, DCAdresse, DCDaten,
        input  VCSchreiben, VCLesen, VCAdresse, VCDaten,
        input  LeseDaten, RAMFertig,
        output BCFertig, DCFertig, VCFertig,
        output DatenAusgabe, Schreiben, Lesen, Adresse, SchreibDaten,
        output WriteMask, Zeitueberschreitung
    );

    modport master (
        output BCSchreiben, BCLesen, BCAdresse, BCDaten,
        output DCSchreiben, DCLesen, DCAdresse, DCDaten,
        output VCSchreiben, VCLesen, VCAdresse, VCDaten,
        output LeseDaten, RAMFertig,
        input  BCFertig, DCFertig, VCFertig,
        input  DatenAusgabe, Schreiben, Lesen, Adresse, SchreibDaten,
        input  WriteMask, Zeitueberschreitung
    );

endinterface

// File: rtl/ram_arbiter_prio.sv
// ram_arbiter_prio
//   Winner selection among the three cache requests.
//   Default: fixed priority BC > DC > VC, purely combinational.
//   Macro ALTERUNG_EN: DC and VC each own an aging counter; a requester whose
//   counter reached ALTER_LIMIT jumps to top priority (DC before VC).
//   Ports:
//     clk_i, rst_ni        clock, synchronous active-low reset (aging only)
//     bc/dc/vc_req_i       combined Schreiben|Lesen request per cache
//     idle_i               arbiter is in IDLE, i.e. owner_o is taken this cycle
//     owner_i              current owner while the arbiter is busy
//     owner_o, valid_o     selected cache and "some request pending"
module ram_arbiter_prio
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ALTER_LIMIT = 15
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   bc_req_i,
    input  logic   dc_req_i,
    input  logic   vc_req_i,
    input  logic   idle_i,
    input  owner_e owner_i,
    output owner_e owner_o,
    output logic   valid_o
);

    assign valid_o = bc_req_i | dc_req_i | vc_req_i;

`ifdef ALTERUNG_EN
    localparam int unsigned AW = (ALTER_LIMIT < 1) ? 1 : $clog2(ALTER_LIMIT + 1);
    localparam logic [AW-1:0] LIMIT_C = AW'(ALTER_LIMIT);

    logic [AW-1:0] dc_age_q, vc_age_q;
    logic          dc_aged, vc_aged;

    assign dc_aged = dc_req_i && (dc_age_q == LIMIT_C);
    assign vc_aged = vc_req_i && (vc_age_q == LIMIT_C);

    always_comb begin
        owner_o = OWNER_BC;
        if (dc_aged)       owner_o = OWNER_DC;
        else if (vc_aged)  owner_o = OWNER_VC;
        else if (bc_req_i) owner_o = OWNER_BC;
        else if (dc_req_i) owner_o = OWNER_DC;
        else if (vc_req_i) owner_o = OWNER_VC;
    end

    // A cache ages while it waits; being served (busy with it as owner)
    // does not count as waiting.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dc_age_q <= '0;
            vc_age_q <= '0;
        end else begin
            if (idle_i && valid_o && owner_o == OWNER_DC)
                dc_age_q <= '0;
            else if (dc_req_i && !(!idle_i && owner_i == OWNER_DC) && dc_age_q != LIMIT_C)
                dc_age_q <= dc_age_q + AW'(1);

            if (idle_i && valid_o && owner_o == OWNER_VC)
                vc_age_q <= '0;
            else if (vc_req_i && !(!idle_i && owner_i == OWNER_VC) && vc_age_q != LIMIT_C)
                vc_age_q <= vc_age_q + AW'(1);
        end
    end
`else
    always_comb begin
        owner_o = OWNER_BC;
        if (bc_req_i)      owner_o = OWNER_BC;
        else if (dc_req_i) owner_o = OWNER_DC;
        else if (vc_req_i) owner_o = OWNER_VC;
    end

    // Aging inputs are only consumed in the ALTERUNG_EN build.
    logic unused_aging;
    assign unused_aging = ^{clk_i, rst_ni, idle_i, owner_i, 32'(ALTER_LIMIT)};
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one external RAM port between instruction (BC), data (DC) and
//   video (VC) caches. One access at a time: IDLE picks a winner and
//   registers command/address/data, GRANT holds them until RAMFertig (or the
//   watchdog expires), RETURN pulses the owner's Fertig for one cycle.
//   Ports:
//     Clock, Reset   rising-edge clock, synchronous active-low reset
//     bus (slave)    cache requests/data/Fertig and RAM strobes/data
//   Parameters: BC/DC/VC_PRAEFIX (upper 3 RAM address bits per cache),
//     TIMEOUT (max GRANT cycles), ALTER_LIMIT (aging threshold).
//   Optional: define ALTERUNG_EN to enable aging priority in ram_arbiter_prio.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter logic [2:0]  BC_PRAEFIX  = 3'b000,
    parameter logic [2:0]  DC_PRAEFIX  = 3'b000,
    parameter logic [2:0]  VC_PRAEFIX  = 3'b000,
    parameter int unsigned TIMEOUT     = 1023,
    parameter int unsigned ALTER_LIMIT = 15
) (
    input logic          Clock,
    input logic          Reset,
    ram_arbiter_if.slave bus
);

    localparam int unsigned   CW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    state_e        state_q;
    owner_e        owner_q;
    logic          schreiben_q, lesen_q;
    logic [25:0]   adresse_q;
    logic [31:0]   schreibdaten_q;
    logic [31:0]   datenausgabe_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    fertig_q;
    logic          timeout_q;

    owner_e        win_owner;
    logic          win_valid;
    logic          sel_wr_d;
    logic [25:0]   sel_adr_d;
    logic [31:0]   sel_dat_d;

    ram_arbiter_prio #(
        .ALTER_LIMIT(ALTER_LIMIT)
    ) u_prio (
        .clk_i   (Clock),
        .rst_ni  (Reset),
        .bc_req_i(bus.BCSchreiben | bus.BCLesen),
        .dc_req_i(bus.DCSchreiben | bus.DCLesen),
        .vc_req_i(bus.VCSchreiben | bus.VCLesen),
        .idle_i  (state_q == ST_IDLE),
        .owner_i (owner_q),
        .owner_o (win_owner),
        .valid_o (win_valid)
    );

    // Command of the winning cache; Schreiben dominates when both are set.
    always_comb begin
        sel_wr_d  = bus.BCSchreiben;
        sel_adr_d = {BC_PRAEFIX, bus.BCAdresse};
        sel_dat_d = bus.BCDaten;
        case (win_owner)
            OWNER_DC: begin
                sel_wr_d  = bus.DCSchreiben;
                sel_adr_d = {DC_PRAEFIX, bus.DCAdresse};
                sel_dat_d = bus.DCDaten;
            end
            OWNER_VC: begin
                sel_wr_d  = bus.VCSchreiben;
                sel_adr_d = {VC_PRAEFIX, bus.VCAdresse};
                sel_dat_d = bus.VCDaten;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWNER_BC;
            schreiben_q    <= 1'b0;
            lesen_q        <= 1'b0;
            adresse_q      <= '0;
            schreibdaten_q <= '0;
            datenausgabe_q <= '0;
            cnt_q          <= '0;
            fertig_q       <= '0;
            timeout_q      <= 1'b0;
        end else begin
            fertig_q  <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        state_q        <= ST_GRANT;
                        owner_q        <= win_owner;
                        schreiben_q    <= sel_wr_d;
                        lesen_q        <= !sel_wr_d;
                        adresse_q      <= sel_adr_d;
                        schreibdaten_q <= sel_dat_d;
                        cnt_q          <= '0;
                    end
                end
                ST_GRANT: begin
                    if (bus.RAMFertig) begin
                        datenausgabe_q <= lesen_q ? bus.LeseDaten : schreibdaten_q;
                        schreiben_q    <= 1'b0;
                        lesen_q        <= 1'b0;
                        fertig_q       <= fertig_onehot(owner_q);
                        state_q        <= ST_RETURN;
                    end else if (cnt_q == TIMEOUT_C) begin
                        datenausgabe_q <= '0;
                        schreiben_q    <= 1'b0;
                        lesen_q        <= 1'b0;
                        fertig_q       <= fertig_onehot(owner_q);
                        timeout_q      <= 1'b1;
                        state_q        <= ST_RETURN;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RETURN: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.Schreiben           = schreiben_q;
    assign bus.Lesen               = lesen_q;
    assign bus.Adresse             = adresse_q;
    assign bus.SchreibDaten        = schreibdaten_q;
    assign bus.DatenAusgabe        = datenausgabe_q;
    assign bus.BCFertig            = fertig_q[0];
    assign bus.DCFertig            = fertig_q[1];
    assign bus.VCFertig            = fertig_q[2];
    assign bus.Zeitueberschreitung = timeout_q;
    assign bus.WriteMask           = WRITE_MASK_ALL;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter: a table of single transactions plus
//   hand-written sequences for latency, grant ordering, watchdog timeout,
//   reset during GRANT and starvation/aging. Inputs change and outputs are
//   sampled on the falling clock edge.
module tb_ram_arbiter;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 Clock = ~Clock;

    ram_arbiter_if bus();

    ram_arbiter #(
        .BC_PRAEFIX (3'b000),
        .DC_PRAEFIX (3'b001),
        .VC_PRAEFIX (3'b000),
        .TIMEOUT    (1023),
        .ALTER_LIMIT(15)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    // req bits: {VCSchreiben, VCLesen, DCSchreiben, DCLesen, BCSchreiben, BCLesen}
    // BC gets adr/wdat, DC gets adr^1/~wdat, VC gets adr^2/wdat^0F0F0F0F.
    typedef struct {
        logic [5:0]  req;
        logic [22:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic        exp_wr;
        logic        exp_rd;
        logic [25:0] exp_adr;
        logic [31:0] exp_wdat;
        logic [2:0]  exp_fertig;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock);
    endtask

    task automatic drive_req(input logic [5:0] r, input logic [22:0] adr, input logic [31:0] wd);
        bus.BCLesen     = r[0];
        bus.BCSchreiben = r[1];
        bus.DCLesen     = r[2];
        bus.DCSchreiben = r[3];
        bus.VCLesen     = r[4];
        bus.VCSchreiben = r[5];
        bus.BCAdresse   = adr;
        bus.DCAdresse   = adr ^ 23'h1;
        bus.VCAdresse   = adr ^ 23'h2;
        bus.BCDaten     = wd;
        bus.DCDaten     = ~wd;
        bus.VCDaten     = wd ^ 32'h0F0F0F0F;
    endtask

    function automatic logic [2:0] fertig_vec();
        return {bus.VCFertig, bus.DCFertig, bus.BCFertig};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] b_adr[3];
        logic [2:0]  b_f[3];
        logic        b_wr[3];
        logic [5:0]  b_mask[3];
        logic [5:0]  r;
        int          n;
        int          vc_at;

        vecs[0] = '{6'b000001, 23'h000010, 32'h00000000, 32'hDEADBEEF, 1'b0, 1'b1, 26'h0000010, 32'h00000000, 3'b001, 32'hDEADBEEF};
        vecs[1] = '{6'b001000, 23'h7FFFFE, 32'hEDCBA987, 32'hAAAA5555, 1'b1, 1'b0, 26'h0FFFFFF, 32'h12345678, 3'b010, 32'h12345678};
        vecs[2] = '{6'b010000, 23'h123454, 32'h00000000, 32'hCAFEF00D, 1'b0, 1'b1, 26'h0123456, 32'h0F0F0F0F, 3'b100, 32'hCAFEF00D};
        vecs[3] = '{6'b000011, 23'h0000AA, 32'h11111111, 32'h99999999, 1'b1, 1'b0, 26'h00000AA, 32'h11111111, 3'b001, 32'h11111111};
        vecs[4] = '{6'b100100, 23'h000100, 32'h0000FFFF, 32'h0BADF00D, 1'b0, 1'b1, 26'h0800101, 32'hFFFF0000, 3'b010, 32'h0BADF00D};
        vecs[5] = '{6'b010110, 23'h055555, 32'hA5A5A5A5, 32'h12121212, 1'b1, 1'b0, 26'h0055555, 32'hA5A5A5A5, 3'b001, 32'hA5A5A5A5};
        vecs[6] = '{6'b001100, 23'h000002, 32'h00000000, 32'h13579BDF, 1'b1, 1'b0, 26'h0800003, 32'hFFFFFFFF, 3'b010, 32'hFFFFFFFF};
        vecs[7] = '{6'b100000, 23'h7FFFFD, 32'h10203040, 32'h00000000, 1'b1, 1'b0, 26'h07FFFFF, 32'h1F2F3F4F, 3'b100, 32'h1F2F3F4F};

        drive_req(6'b0, 23'h0, 32'h0);
        bus.RAMFertig = 1'b0;
        bus.LeseDaten = 32'h0;

        // Reset state
        repeat (3) step();
        check("rst_schreiben", 32'(bus.Schreiben), 32'd0);
        check("rst_lesen", 32'(bus.Lesen), 32'd0);
        check("rst_adresse", 32'(bus.Adresse), 32'd0);
        check("rst_schreibdaten", bus.SchreibDaten, 32'd0);
        check("rst_datenausgabe", bus.DatenAusgabe, 32'd0);
        check("rst_fertig", 32'(fertig_vec()), 32'd0);
        check("rst_timeout", 32'(bus.Zeitueberschreitung), 32'd0);
        check("writemask", 32'(bus.WriteMask), 32'hF);
        Reset = 1'b1;
        step();

        // Table: request in IDLE, RAMFertig in first GRANT cycle, drop in RETURN
        for (int i = 0; i < 8; i++) begin
            drive_req(vecs[i].req, vecs[i].adr, vecs[i].wdat);
            step();
            check($sformatf("v%0d_schreiben", i), 32'(bus.Schreiben), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_lesen", i), 32'(bus.Lesen), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d_adresse", i), 32'(bus.Adresse), 32'(vecs[i].exp_adr));
            check($sformatf("v%0d_schreibdaten", i), bus.SchreibDaten, vecs[i].exp_wdat);
            check($sformatf("v%0d_fertig_grant", i), 32'(fertig_vec()), 32'd0);
            bus.RAMFertig = 1'b1;
            bus.LeseDaten = vecs[i].rdat;
            step();
            bus.RAMFertig = 1'b0;
            check($sformatf("v%0d_fertig", i), 32'(fertig_vec()), 32'(vecs[i].exp_fertig));
            check($sformatf("v%0d_dout", i), bus.DatenAusgabe, vecs[i].exp_dout);
            check($sformatf("v%0d_strobes_ret", i), 32'({bus.Schreiben, bus.Lesen}), 32'd0);
            check($sformatf("v%0d_timeout", i), 32'(bus.Zeitueberschreitung), 32'd0);
            drive_req(6'b0, vecs[i].adr, vecs[i].wdat);
            step();
            check($sformatf("v%0d_fertig_idle", i), 32'(fertig_vec()), 32'd0);
        end

        // RAMFertig while IDLE is ignored
        bus.RAMFertig = 1'b1;
        bus.LeseDaten = 32'hFFFFFFFF;
        step();
        bus.RAMFertig = 1'b0;
        check("idle_ramfertig_fertig", 32'(fertig_vec()), 32'd0);
        check("idle_ramfertig_strobes", 32'({bus.Schreiben, bus.Lesen}), 32'd0);
        check("idle_ramfertig_dout", bus.DatenAusgabe, 32'h1F2F3F4F);
        step();

        // Latency: three GRANT cycles, RAMFertig in the third
        bus.BCLesen   = 1'b1;
        bus.BCAdresse = 23'h000010;
        step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("lat_lesen_%0d", i), 32'(bus.Lesen), 32'd1);
            check($sformatf("lat_adresse_%0d", i), 32'(bus.Adresse), 32'h0000010);
            check($sformatf("lat_fertig_%0d", i), 32'(fertig_vec()), 32'd0);
            if (i == 2) begin
                bus.RAMFertig = 1'b1;
                bus.LeseDaten = 32'hDEADBEEF;
            end
            step();
        end
        bus.RAMFertig = 1'b0;
        check("lat_bcfertig", 32'(fertig_vec()), 32'b001);
        check("lat_dout", bus.DatenAusgabe, 32'hDEADBEEF);
        bus.BCLesen = 1'b0;
        step();
        check("lat_bcfertig_once", 32'(fertig_vec()), 32'd0);
        check("lat_lesen_off", 32'(bus.Lesen), 32'd0);

        // All three at once: BC, DC, VC with one IDLE cycle between grants
        b_adr  = '{26'h0000200, 26'h0800201, 26'h0000202};
        b_f    = '{3'b001, 3'b010, 3'b100};
        b_wr   = '{1'b0, 1'b1, 1'b0};
        b_mask = '{6'b000011, 6'b001100, 6'b110000};
        r = 6'b011001;
        drive_req(r, 23'h000200, 32'h55AA55AA);
        step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ord%0d_adresse", k), 32'(bus.Adresse), 32'(b_adr[k]));
            check($sformatf("ord%0d_schreiben", k), 32'(bus.Schreiben), 32'(b_wr[k]));
            bus.RAMFertig = 1'b1;
            bus.LeseDaten = 32'h0;
            step();
            bus.RAMFertig = 1'b0;
            check($sformatf("ord%0d_fertig", k), 32'(fertig_vec()), 32'(b_f[k]));
            r = r & ~b_mask[k];
            drive_req(r, 23'h000200, 32'h55AA55AA);
            step();
            check($sformatf("ord%0d_idle_gap", k), 32'({bus.Schreiben, bus.Lesen}), 32'd0);
            check($sformatf("ord%0d_fertig_off", k), 32'(fertig_vec()), 32'd0);
            step();
        end

        // Watchdog: VC read, RAM never answers
        bus.VCLesen   = 1'b1;
        bus.VCAdresse = 23'h000300;
        step();
        check("to_lesen", 32'(bus.Lesen), 32'd1);
        check("to_adresse", 32'(bus.Adresse), 32'h0000300);
        n = 0;
        while (!bus.VCFertig && n < 1100) begin
            step();
            n++;
        end
        check("to_cycles", 32'(n), 32'd1024);
        check("to_pulse", 32'(bus.Zeitueberschreitung), 32'd1);
        check("to_vcfertig", 32'(fertig_vec()), 32'b100);
        check("to_dout", bus.DatenAusgabe, 32'd0);
        bus.VCLesen = 1'b0;
        step();
        check("to_pulse_off", 32'(bus.Zeitueberschreitung), 32'd0);
        check("to_fertig_off", 32'(fertig_vec()), 32'd0);
        check("to_idle", 32'({bus.Schreiben, bus.Lesen}), 32'd0);

        // Reset in GRANT, coinciding with RAMFertig
        bus.DCLesen   = 1'b1;
        bus.DCAdresse = 23'h000111;
        bus.DCDaten   = 32'h44444444;
        step();
        step();
        check("rg_lesen", 32'(bus.Lesen), 32'd1);
        Reset = 1'b0;
        bus.RAMFertig = 1'b1;
        bus.LeseDaten = 32'h66666666;
        step();
        check("rg_strobes", 32'({bus.Schreiben, bus.Lesen}), 32'd0);
        check("rg_adresse", 32'(bus.Adresse), 32'd0);
        check("rg_schreibdaten", bus.SchreibDaten, 32'd0);
        check("rg_dout", bus.DatenAusgabe, 32'd0);
        check("rg_fertig", 32'(fertig_vec()), 32'd0);
        check("rg_timeout", 32'(bus.Zeitueberschreitung), 32'd0);
        Reset = 1'b1;
        bus.RAMFertig = 1'b0;
        bus.DCLesen = 1'b0;
        step();
        check("rg_fertig_after", 32'(fertig_vec()), 32'd0);
        bus.BCLesen   = 1'b1;
        bus.BCAdresse = 23'h000400;
        step();
        check("rg_new_lesen", 32'(bus.Lesen), 32'd1);
        check("rg_new_adresse", 32'(bus.Adresse), 32'h0000400);
        bus.RAMFertig = 1'b1;
        bus.LeseDaten = 32'h77777777;
        step();
        bus.RAMFertig = 1'b0;
        check("rg_new_fertig", 32'(fertig_vec()), 32'b001);
        check("rg_new_dout", bus.DatenAusgabe, 32'h77777777);
        bus.BCLesen = 1'b0;
        step();

        // BC re-requests every IDLE while VC is held
        bus.VCLesen   = 1'b1;
        bus.VCAdresse = 23'h000600;
        bus.BCAdresse = 23'h000500;
        vc_at = -1;
        for (int t = 0; t < 6; t++) begin
            bus.BCLesen = 1'b1;
            step();
            if (bus.Adresse == 26'h0000600 && vc_at < 0) vc_at = t;
            bus.RAMFertig = 1'b1;
            step();
            bus.RAMFertig = 1'b0;
            bus.BCLesen = 1'b0;
            if (vc_at == t) bus.VCLesen = 1'b0;
            step();
        end
`ifdef ALTERUNG_EN
        check("age_vc_grant_slot", 32'(vc_at), 32'd5);
`else
        check("starve_vc_never", 32'(vc_at), 32'hFFFFFFFF);
        step();
        check("starve_vc_adresse", 32'(bus.Adresse), 32'h0000600);
        check("starve_vc_lesen", 32'(bus.Lesen), 32'd1);
        bus.RAMFertig = 1'b1;
        bus.LeseDaten = 32'h0;
        step();
        bus.RAMFertig = 1'b0;
        check("starve_vc_fertig", 32'(fertig_vec()), 32'b100);
        bus.VCLesen = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Arbitrates the shared external RAM port between three caches: instruction cache (BC), data cache (DC) and video cache (VC).
- Holds one access at a time and drives registered command/address/data to the RAM.
- Captures read data on RAMFertig, then returns it to the winning cache with a one-cycle Fertig pulse.
- Also provides a watchdog timeout for a RAM that never answers.

Parameters:
- BC_PRAEFIX, 3'b000, upper 3 address bits prepended to BC addresses.
- DC_PRAEFIX, 3'b000, upper 3 address bits prepended to DC addresses.
- VC_PRAEFIX, 3'b000, upper 3 address bits prepended to VC addresses.
- TIMEOUT, 1023, max cycles in GRANT before abort (counter width = clog2(TIMEOUT+1)).
- ALTER_LIMIT, 15, aging threshold; used only with ALTERUNG_EN.

Ports:
- Clock  in  1  single system clock, all logic on rising edge
- Reset  in  1  synchronous, active-low reset (0 = reset)
- BCSchreiben/BCLesen, DCSchreiben/DCLesen, VCSchreiben/VCLesen  in  1 each  cache write/read request, level, held until the cache's Fertig
- BCAdresse/DCAdresse/VCAdresse  in  23  word address
- BCDaten/DCDaten/VCDaten  in  32  write data
- LeseDaten  in  32  RAM read data, valid when RAMFertig=1
- RAMFertig  in  1  one-cycle RAM completion strobe
- BCFertig/DCFertig/VCFertig  out  1  one-cycle completion pulse to the owning cache
- DatenAusgabe  out  32  registered read data, valid during the Fertig pulse
- Schreiben/Lesen  out  1  registered RAM strobes
- Adresse  out  26  registered: {PRAEFIX_x, Adresse_x}
- SchreibDaten  out  32  registered write data
- WriteMask  out  4  constant 4'b1111
- Zeitueberschreitung  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (Reset=0 at clock edge):
  - State goes to IDLE.
  - All strobes, Fertig outputs and Zeitueberschreitung are 0.
  - Adresse, SchreibDaten, DatenAusgabe and the timeout counter are 0.
  - Aging counters are 0.
  - Reset during GRANT abandons the access: no Fertig pulse, strobes are 0 next cycle.
- States: IDLE, GRANT, RETURN (one-hot, 3 bits).
- IDLE:
  - With any request pending, select the winner, latch owner, command, address and data, and go to GRANT.
  - With no request, remain in IDLE.
- Priority: fixed BC > DC > VC.
- Same cache asserting both Schreiben and Lesen: treated as a write.
- GRANT:
  - Schreiben/Lesen/Adresse/SchreibDaten stay stable.
  - The timeout counter increments every cycle.
  - On RAMFertig=1: DatenAusgabe <= LeseDaten for reads, SchreibDaten for writes; strobes drop; go to RETURN.
  - On counter == TIMEOUT without RAMFertig: strobes drop, DatenAusgabe <= 0, Zeitueberschreitung pulses in RETURN, go to RETURN.
- RETURN:
  - Exactly one owner's Fertig is 1 for exactly one cycle.
  - Always go to IDLE; the cache drops its request on the edge where it samples Fertig.
- Latency:
  - Request seen in cycle n puts the strobes on RAM in cycle n+1.
  - RAMFertig in cycle m produces Fertig and DatenAusgabe in cycle m+1.
  - Minimum spacing between back-to-back grants: one IDLE cycle.
- A request withdrawn mid-GRANT still completes and still pulses Fertig.
- A RAMFertig seen outside GRANT is ignored.

Optional Feature:
- Macro: ALTERUNG_EN.
- Enabled:
  - DC and VC each get an aging counter that increments per cycle while requesting and not the owner, saturating at ALTER_LIMIT.
  - A requester at ALTER_LIMIT takes top priority in IDLE; if DC and VC are both aged, DC wins.
  - A counter clears when its cache is granted.
- Disabled: strict fixed priority, no counters synthesized.

Decomposition:
- Package ram_arbiter_pkg: state encodings, owner IDs (OWNER_BC/DC/VC, 2 bits), WRITE_MASK_ALL = 4'b1111.
- Sub-module ram_arbiter_prio: combinational winner select plus the optional aging counters; outputs owner ID and a grant-valid flag.

Test Plan:
- BCLesen=1, BCAdresse=23'h000010, RAMFertig 3 cycles after grant with LeseDaten=32'hDEADBEEF -> Lesen=1 with Adresse=26'h0000010 for 3 cycles; BCFertig=1 for one cycle with DatenAusgabe=32'hDEADBEEF.
- BCLesen, DCSchreiben and VCLesen all asserted together -> grant order BC, DC, VC; each Fertig pulsed once; one IDLE cycle between grants.
- DCSchreiben=1, DCDaten=32'h12345678, DC_PRAEFIX=3'b001, DCAdresse=23'h7FFFFF -> Schreiben=1, Adresse=26'h0FFFFFF, SchreibDaten=32'h12345678; DCFertig after RAMFertig.
- VCLesen held, RAMFertig never asserted, TIMEOUT=1023 -> 1024 cycles after grant: VCFertig=1, Zeitueberschreitung=1, DatenAusgabe=0, then IDLE.
- Reset=0 asserted mid-GRANT -> next cycle all outputs 0, no Fertig pulse; a new request after release is granted normally.
- With ALTERUNG_EN, ALTER_LIMIT=15, BC re-requesting continuously and VC held -> VC granted no later than its 16th pending cycle; without the macro, VC waits until BC goes idle.
